// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of fetch_sequencer: instruction-memory port, redirect request,
// decode valid/ready handshake and run status.
interface fetch_sequencer_if;
  logic        start;
  logic [31:0] fetchAddr;
  logic [31:0] instIn;
  logic        redirect;
  logic [31:0] redirectAddr;
  logic        instValid;
  logic [31:0] instOut;
  logic [31:0] instPc;
  logic        instReady;
  logic        running;
  logic        halted;

  // master: the sequencer itself; slave: memory, branch unit and decode around it
  modport master (
    input  start, instIn, redirect, redirectAddr, instReady,
    output fetchAddr, instValid, instOut, instPc, running, halted
  );

  modport slave (
    output start, instIn, redirect, redirectAddr, instReady,
    input  fetchAddr, instValid, instOut, instPc, running, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner: fetches one word per cycle from a combinational
// instruction memory into a small {pc, word} FIFO that feeds decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0064,
  parameter logic [31:0] END_PC    = 32'h0000_0070,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [31:0]        buf_pc_q   [BUF_DEPTH];
  logic [31:0]        buf_inst_q [BUF_DEPTH];

  logic        push;
  logic        pop;
  logic        redirect_en;
  logic        in_window;
  logic [31:0] target;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    target      = bus.redirectAddr & ~32'd3;
    in_window   = (target >= RESET_PC) && (target <= END_PC);
    pop         = bus.instValid && bus.instReady;
    redirect_en = bus.redirect && (state_q != S_IDLE);
    push        = (state_q == S_RUN) && !redirect_en &&
                  ((count_q < CNT_W'(BUF_DEPTH)) || pop);

    case (state_q)
      S_IDLE: if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (push) begin
          pc_d = pc_q + 32'd4;
          if (pc_q == END_PC) state_d = S_HALT;
        end
      end
      S_HALT:  ;
      default: state_d = S_IDLE;
    endcase

    // A redirect discards the whole buffer, including any same-cycle push/pop.
    if (redirect_en) begin
      pc_d    = target;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      state_d = in_window ? S_RUN : S_HALT;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      // NOTE: the buffer storage is cleared on reset because instOut/instPc
      // must read zero afterwards; plain storage would normally skip this.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]   <= '0;
        buf_inst_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push) begin
        buf_pc_q[tail_q]   <= pc_q;
        buf_inst_q[tail_q] <= bus.instIn;
      end
    end
  end

  assign bus.fetchAddr = pc_q;
  assign bus.instValid = (count_q != '0);
  assign bus.instOut   = buf_inst_q[head_q];
  assign bus.instPc    = buf_pc_q[head_q];
  assign bus.running   = (state_q == S_RUN);
  assign bus.halted    = (state_q == S_HALT) && (count_q == '0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// ready/redirect traffic scored against a program-order model.
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0064;
  localparam logic [31:0] END_PC   = 32'h0000_0070;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(RESET_PC), .END_PC(END_PC), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] golden_pc   [4] = '{32'h64, 32'h68, 32'h6C, 32'h70};
  logic [31:0] golden_inst [4] = '{32'h8C22_0000, 32'h8C23_0004, 32'h8C24_0008, 32'h8C25_000C};

  // Program image: the four loaded words inside the window, a recognisable filler outside.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a >= RESET_PC && a <= END_PC)
      return 32'h8C22_0000 + ((a - RESET_PC) >> 2) * 32'h0001_0004;
    return 32'hA500_0000 ^ a;
  endfunction

  assign bus.instIn = imem_word(bus.fetchAddr);

  function automatic logic [64:0] head_obs();
    return {bus.instValid, bus.instPc, bus.instOut};
  endfunction

  task automatic do_reset();
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirectAddr = '0;
    bus.instReady    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_full(input string tag);
    int t = 0;
    while (!(bus.instValid && bus.fetchAddr == 32'h6C) && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 20) begin
      n_bad++;
      $display("FAIL %s_wait_full: timed out after %0d cycles", tag, t);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset();
    n_cmp++;
    if (bus.fetchAddr !== RESET_PC) begin
      n_bad++; $display("FAIL reset_fetchAddr: got %h want %h", bus.fetchAddr, RESET_PC);
    end
    n_cmp++;
    if (head_obs() !== 65'd0) begin
      n_bad++; $display("FAIL reset_head: got %h want 0", head_obs());
    end
    n_cmp++;
    if ({bus.running, bus.halted} !== 2'b00) begin
      n_bad++; $display("FAIL reset_status: got %b want 00", {bus.running, bus.halted});
    end
    bus.redirect = 1'b1; bus.redirectAddr = 32'h68;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_cmp++;
    if ({bus.fetchAddr, bus.running, bus.instValid} !== {RESET_PC, 2'b00}) begin
      n_bad++; $display("FAIL idle_redirect_ignored: got %h/%b/%b", bus.fetchAddr, bus.running, bus.instValid);
    end
  endtask

  task automatic test_stream();
    do_reset();
    bus.start = 1'b1; bus.instReady = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if ({bus.running, bus.instValid, bus.fetchAddr} !== {2'b10, RESET_PC}) begin
      n_bad++; $display("FAIL stream_start: got run=%b valid=%b addr=%h", bus.running, bus.instValid, bus.fetchAddr);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (head_obs() !== {1'b1, golden_pc[k], golden_inst[k]}) begin
        n_bad++; $display("FAIL stream_word%0d: got %h want %h", k, head_obs(), {1'b1, golden_pc[k], golden_inst[k]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.instValid, bus.halted, bus.running, bus.fetchAddr} !== {3'b010, 32'h74}) begin
      n_bad++; $display("FAIL stream_end: got valid=%b halted=%b run=%b addr=%h", bus.instValid, bus.halted, bus.running, bus.fetchAddr);
    end
  endtask

  task automatic test_stall();
    int t = 0;
    do_reset();
    bus.start = 1'b1; bus.instReady = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.instValid && t < 10) begin @(negedge clk); t++; end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (head_obs() !== {1'b1, golden_pc[0], golden_inst[0]}) begin
        n_bad++; $display("FAIL stall_hold%0d: got %h want %h", i, head_obs(), {1'b1, golden_pc[0], golden_inst[0]});
      end
      if (i > 0) begin
        n_cmp++;
        if (bus.fetchAddr !== 32'h6C) begin
          n_bad++; $display("FAIL stall_addr%0d: got %h want 0000006c", i, bus.fetchAddr);
        end
      end
      if (i < 5) @(negedge clk);
    end
    bus.instReady = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (head_obs() !== {1'b1, golden_pc[k], golden_inst[k]}) begin
        n_bad++; $display("FAIL stall_release%0d: got %h want %h", k, head_obs(), {1'b1, golden_pc[k], golden_inst[k]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.instValid, bus.halted} !== 2'b01) begin
      n_bad++; $display("FAIL stall_drain: got valid=%b halted=%b", bus.instValid, bus.halted);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.start = 1'b1; bus.instReady = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_full("redir");
    bus.redirect = 1'b1; bus.redirectAddr = 32'h69;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_cmp++;
    if ({bus.instValid, bus.running, bus.fetchAddr} !== {2'b01, 32'h68}) begin
      n_bad++; $display("FAIL redir_flush: got valid=%b run=%b addr=%h", bus.instValid, bus.running, bus.fetchAddr);
    end
    @(negedge clk);
    n_cmp++;
    if (head_obs() !== {1'b1, golden_pc[1], golden_inst[1]}) begin
      n_bad++; $display("FAIL redir_target: got %h want %h", head_obs(), {1'b1, golden_pc[1], golden_inst[1]});
    end
  endtask

  task automatic test_halt_redirect();
    int t = 0;
    bus.instReady = 1'b1;
    while (!bus.halted && t < 20) begin @(negedge clk); t++; end
    n_cmp++;
    if (t >= 20) begin
      n_bad++; $display("FAIL halt_wait: not halted after %0d cycles", t);
    end
    bus.redirect = 1'b1; bus.redirectAddr = 32'h64;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_cmp++;
    if ({bus.running, bus.halted, bus.instValid} !== 3'b100) begin
      n_bad++; $display("FAIL halt_restart: got run=%b halted=%b valid=%b", bus.running, bus.halted, bus.instValid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (head_obs() !== {1'b1, golden_pc[k], golden_inst[k]}) begin
        n_bad++; $display("FAIL halt_rerun%0d: got %h want %h", k, head_obs(), {1'b1, golden_pc[k], golden_inst[k]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.halted !== 1'b1) begin
      n_bad++; $display("FAIL halt_again: got halted=%b want 1", bus.halted);
    end
    bus.redirect = 1'b1; bus.redirectAddr = 32'h100;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_cmp++;
    if ({bus.running, bus.halted, bus.instValid, bus.fetchAddr} !== {3'b010, 32'h100}) begin
      n_bad++; $display("FAIL halt_outside: got run=%b halted=%b valid=%b addr=%h", bus.running, bus.halted, bus.instValid, bus.fetchAddr);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.instValid, bus.fetchAddr} !== {1'b0, 32'h100}) begin
      n_bad++; $display("FAIL halt_nofetch: got valid=%b addr=%h", bus.instValid, bus.fetchAddr);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    bus.start = 1'b1; bus.instReady = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_full("rst");
    reset = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({head_obs(), bus.fetchAddr, bus.running} !== {65'd0, RESET_PC, 1'b0}) begin
      n_bad++; $display("FAIL rst_mid: got head=%h addr=%h run=%b", head_obs(), bus.fetchAddr, bus.running);
    end
    reset = 1'b0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.running, bus.instValid, bus.fetchAddr} !== {2'b00, RESET_PC}) begin
      n_bad++; $display("FAIL rst_stay_idle: got run=%b valid=%b addr=%h", bus.running, bus.instValid, bus.fetchAddr);
    end
    bus.start = 1'b1; bus.instReady = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (head_obs() !== {1'b1, golden_pc[0], golden_inst[0]}) begin
      n_bad++; $display("FAIL rst_resume: got %h want %h", head_obs(), {1'b1, golden_pc[0], golden_inst[0]});
    end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    bus.start = 1'b1; bus.instReady = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_full("rpop");
    // The head (0x64) is popped in the redirect cycle and must be discarded.
    bus.instReady = 1'b1; bus.redirect = 1'b1; bus.redirectAddr = 32'h70;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_cmp++;
    if (bus.instValid !== 1'b0) begin
      n_bad++; $display("FAIL rpop_flush: got valid=%b want 0", bus.instValid);
    end
    @(negedge clk);
    n_cmp++;
    if (head_obs() !== {1'b1, golden_pc[3], golden_inst[3]}) begin
      n_bad++; $display("FAIL rpop_target: got %h want %h", head_obs(), {1'b1, golden_pc[3], golden_inst[3]});
    end
  endtask

  // Model: decode must see consecutive words starting at the last start/redirect
  // target and ending at END_PC; a target outside the window yields nothing.
  task automatic test_random(input int round);
    logic [31:0] exp_next;
    logic [63:0] held;
    logic        hold_prev = 1'b0;
    logic        redir_prev = 1'b0;
    logic        done = 1'b0;
    int          ready_pct = 25 + 20 * round;
    do_reset();
    bus.start = 1'b1;
    exp_next  = RESET_PC;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (redir_prev) begin
        n_cmp++;
        if (bus.instValid !== 1'b0) begin
          n_bad++; $display("FAIL rnd%0d_flush c%0d: got valid=%b want 0", round, cyc, bus.instValid);
        end
      end
      if (hold_prev && bus.instValid) begin
        n_cmp++;
        if ({bus.instPc, bus.instOut} !== held) begin
          n_bad++; $display("FAIL rnd%0d_stable c%0d: got %h want %h", round, cyc, {bus.instPc, bus.instOut}, held);
        end
      end
      if (bus.halted && !redir_prev) begin
        n_cmp++;
        if (exp_next >= RESET_PC && exp_next <= END_PC) begin
          n_bad++; $display("FAIL rnd%0d_early_halt c%0d: halted with %h still owed", round, cyc, exp_next);
        end
        done = 1'b1;
      end else begin
        bus.instReady = ($urandom_range(0, 99) < ready_pct);
        bus.redirect  = (cyc < 150) && ($urandom_range(0, 11) == 0);
        bus.redirectAddr = 32'h50 + $urandom_range(0, 63);
        if (bus.instValid && bus.instReady && !bus.redirect) begin
          n_cmp++;
          if (!(exp_next >= RESET_PC && exp_next <= END_PC) ||
              {bus.instPc, bus.instOut} !== {exp_next, imem_word(exp_next)}) begin
            n_bad++; $display("FAIL rnd%0d_pop c%0d: got %h want %h", round, cyc,
                              {bus.instPc, bus.instOut}, {exp_next, imem_word(exp_next)});
          end
          exp_next = exp_next + 32'd4;
        end
        if (bus.redirect) exp_next = bus.redirectAddr & ~32'd3;
        hold_prev  = bus.instValid && !bus.instReady && !bus.redirect;
        held       = {bus.instPc, bus.instOut};
        redir_prev = bus.redirect;
        @(negedge clk);
      end
    end
    bus.redirect = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++; $display("FAIL rnd%0d_timeout: never halted", round);
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirectAddr = '0;
    bus.instReady    = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_halt_redirect();
    test_reset_midrun();
    test_redirect_pop();
    for (int r = 0; r < 4; r++) test_random(r);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
